// File: rtl/regfile_writeback_queue_pkg.sv
// Shared constants and the pending-write entry type for the register-file
// writeback queue.
package regfile_wb_pkg;
  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;
  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic             valid;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Producer, register-file and forwarding signals of the writeback queue.
// master = surrounding pipeline / environment, slave = the queue itself.
interface regfile_writeback_queue_if
  import regfile_wb_pkg::*;
#(
  parameter int AW = WB_AW,
  parameter int DW = WB_DW
);
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          rf_hold;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [AW-1:0] fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output rf_hold, fwd_addr,
    input  alu_ready, mem_ready, rf_we, rf_wa, rf_wd, fwd_hit, fwd_data
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  rf_hold, fwd_addr,
    output alu_ready, mem_ready, rf_we, rf_wa, rf_wd, fwd_hit, fwd_data
  );
endinterface

// File: rtl/regfile_writeback_queue_fifo.sv
// In-order pending-write storage: pointers, occupancy, head presentation and
// a parallel youngest-match search for operand forwarding.
module regfile_wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  wb_entry_t                push_ent,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [WB_AW-1:0]         fwd_addr,
  output logic                     fwd_hit,
  output logic [WB_DW-1:0]         fwd_data
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DEPTH-1:0] vld;
  logic [WB_AW-1:0] addr_mem [DEPTH];
  logic [WB_DW-1:0] data_mem [DEPTH];
  logic [PW-1:0]    idx;

  // Control state: pointers, occupancy and per-slot valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_ent.addr;
      data_mem[wr_ptr] <= push_ent.data;
    end
  end

  always_comb begin
    head.valid = (count != '0);
    head.addr  = head.valid ? addr_mem[rd_ptr] : '0;
    head.data  = head.valid ? data_mem[rd_ptr] : '0;
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (vld[idx] && (addr_mem[idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[idx];
      end
    end
  end
endmodule

// File: rtl/regfile_writeback_queue.sv
// Writeback queue top: mem-over-alu arbitration, optional r0 filtering
// (WB_DROP_R0_EN) and register-file write port driven from the FIFO head.
module regfile_writeback_queue
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_writeback_queue_if.slave bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          not_full;
  logic          take_mem;
  logic          take_alu;
  logic          push;
  logic          pop;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          fwd_r0;
  logic          fifo_hit;
  logic [DW-1:0] fifo_data;
  wb_entry_t     push_ent;
  wb_entry_t     head;

  // Readies look only at occupancy, so a same-cycle pop never opens a full queue.
  always_comb begin
    not_full      = rst_n && (count != CW'(DEPTH));
    bus.mem_ready = not_full;
    bus.alu_ready = not_full && !bus.mem_valid;
    take_mem      = bus.mem_valid && not_full;
    take_alu      = bus.alu_valid && not_full && !bus.mem_valid;
    sel_addr      = take_mem ? bus.mem_addr : bus.alu_addr;
    sel_data      = take_mem ? bus.mem_data : bus.alu_data;
    push          = take_mem || take_alu;
`ifdef WB_DROP_R0_EN
    if (sel_addr == '0)
      push = 1'b0;
`endif
    push_ent.valid = push;
    push_ent.addr  = sel_addr;
    push_ent.data  = sel_data;
  end

`ifdef WB_DROP_R0_EN
  assign fwd_r0 = (bus.fwd_addr == '0);
`else
  assign fwd_r0 = 1'b0;
`endif

  assign pop          = head.valid && !bus.rf_hold;
  assign bus.rf_we    = head.valid;
  assign bus.rf_wa    = head.addr;
  assign bus.rf_wd    = head.data;
  assign bus.fwd_hit  = fifo_hit && !fwd_r0;
  assign bus.fwd_data = bus.fwd_hit ? fifo_data : '0;

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_ent (push_ent),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .fwd_addr (bus.fwd_addr),
    .fwd_hit  (fifo_hit),
    .fwd_data (fifo_data)
  );
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed and randomized bench for regfile_writeback_queue against a
// queue-based reference model; honours WB_DROP_R0_EN when defined.
module tb_regfile_writeback_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
`ifdef WB_DROP_R0_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] count;

  regfile_writeback_queue_if #(.AW(AW), .DW(DW)) bus ();

  regfile_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit            rdy;
    bit            hit;
    logic [DW-1:0] fdata;
    rdy   = rst_n && (q.size() < DEPTH);
    hit   = 1'b0;
    fdata = '0;
    foreach (q[i]) begin
      if (q[i].a == bus.fwd_addr) begin
        hit   = 1'b1;
        fdata = q[i].d;
      end
    end
    if (DROP_EN && bus.fwd_addr == '0) begin
      hit   = 1'b0;
      fdata = '0;
    end
    chk({tag, ".count"},     32'(count),         32'(q.size()));
    chk({tag, ".mem_ready"}, 32'(bus.mem_ready), 32'(rdy));
    chk({tag, ".alu_ready"}, 32'(bus.alu_ready), 32'(rdy && !bus.mem_valid));
    chk({tag, ".rf_we"},     32'(bus.rf_we),     32'(q.size() != 0));
    chk({tag, ".rf_wa"},     32'(bus.rf_wa),     (q.size() != 0) ? 32'(q[0].a) : 32'd0);
    chk({tag, ".rf_wd"},     bus.rf_wd,          (q.size() != 0) ? q[0].d : 32'd0);
    chk({tag, ".fwd_hit"},   32'(bus.fwd_hit),   32'(hit));
    chk({tag, ".fwd_data"},  bus.fwd_data,       fdata);
  endtask

  // Check outputs for the current inputs, then advance one edge and the model.
  task automatic clk_step(input string tag);
    bit   rdy;
    bit   do_pop;
    bit   do_push;
    ent_t in;
    #1 check_all(tag);
    @(posedge clk);
    rdy     = rst_n && (q.size() < DEPTH);
    do_pop  = rst_n && (q.size() != 0) && !bus.rf_hold;
    do_push = 1'b0;
    in      = '0;
    if (rdy && bus.mem_valid) begin
      in      = {bus.mem_addr, bus.mem_data};
      do_push = 1'b1;
    end else if (rdy && bus.alu_valid) begin
      in      = {bus.alu_addr, bus.alu_data};
      do_push = 1'b1;
    end
    if (do_pop)
      void'(q.pop_front());
    if (do_push && !(DROP_EN && in.a == '0))
      q.push_back(in);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_addr  = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
    bus.rf_hold   = 1'b0;
    bus.fwd_addr  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    // Reset state
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ALU write
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'h11;
    clk_step("t1_offer");
    bus.alu_valid = 1'b0;
    chk("t1_count_after_push", 32'(count), 32'd1);
    #1;
    chk("t1_rf_we", 32'(bus.rf_we), 32'd1);
    chk("t1_rf_wa", 32'(bus.rf_wa), 32'd3);
    chk("t1_rf_wd", bus.rf_wd, 32'h11);
    clk_step("t1_drain");
    chk("t1_count_empty", 32'(count), 32'd0);

    // mem wins over alu
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd2; bus.mem_data = 32'hAA;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd4; bus.alu_data = 32'hBB;
    clk_step("t2_both");
    bus.mem_valid = 1'b0;
    #1 chk("t2_first_commit", 32'(bus.rf_wa), 32'd2);
    clk_step("t2_alu");
    bus.alu_valid = 1'b0;
    #1 chk("t2_second_commit", 32'(bus.rf_wa), 32'd4);
    repeat (2) clk_step("t2_drain");

    // Fill while held, then release with a pending mem offer
    bus.rf_hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = AW'(10 + i); bus.alu_data = 32'h100 + i;
      clk_step("t3_fill");
    end
    bus.alu_valid = 1'b0;
    #1;
    chk("t3_full_count", 32'(count), 32'd4);
    chk("t3_full_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("t3_full_rf_wa", 32'(bus.rf_wa), 32'd10);
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd20; bus.mem_data = 32'h200;
    clk_step("t3_full_hold");
    bus.rf_hold = 1'b0;
    #1 chk("t3_release_mem_ready", 32'(bus.mem_ready), 32'd0);
    clk_step("t3_release");
    chk("t3_count_after_pop", 32'(count), 32'd3);
    clk_step("t3_accept");
    bus.mem_valid = 1'b0;
    repeat (4) clk_step("t3_drain");
    chk("t3_drained", 32'(count), 32'd0);

    // Forwarding picks the youngest matching entry
    bus.rf_hold = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'd1;
    clk_step("t4_push1");
    bus.alu_data = 32'd2;
    clk_step("t4_push2");
    bus.alu_valid = 1'b0;
    bus.fwd_addr = 5'd5;
    #1;
    chk("t4_fwd5_hit", 32'(bus.fwd_hit), 32'd1);
    chk("t4_fwd5_data", bus.fwd_data, 32'd2);
    bus.fwd_addr = 5'd6;
    #1;
    chk("t4_fwd6_hit", 32'(bus.fwd_hit), 32'd0);
    chk("t4_fwd6_data", bus.fwd_data, 32'd0);
    bus.rf_hold = 1'b0;
    bus.fwd_addr = 5'd5;
    repeat (3) clk_step("t4_drain");

    // Asynchronous reset with pending entries
    bus.rf_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = AW'(7 + i); bus.alu_data = 32'h70 + i;
      clk_step("t5_fill");
    end
    bus.alu_valid = 1'b0;
    bus.fwd_addr = 5'd8;
    #1 chk("t5_pending", 32'(count), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    q.delete();
    chk("t5_rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("t5_rst_count", 32'(count), 32'd0);
    chk("t5_rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("t5_rst_fwd_hit", 32'(bus.fwd_hit), 32'd0);
    bus.rf_hold = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) clk_step("t5_in_reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    clk_step("t5_after_reset");
    chk("t5_no_write", 32'(bus.rf_we), 32'd0);

    // Register 0 handling
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 32'h55;
    bus.fwd_addr = 5'd0;
    #1 chk("t6_r0_ready", 32'(bus.alu_ready), 32'd1);
    clk_step("t6_r0_offer");
    bus.alu_valid = 1'b0;
    chk("t6_r0_count", 32'(count), DROP_EN ? 32'd0 : 32'd1);
    #1;
    chk("t6_r0_rf_we", 32'(bus.rf_we), DROP_EN ? 32'd0 : 32'd1);
    chk("t6_r0_fwd_hit", 32'(bus.fwd_hit), DROP_EN ? 32'd0 : 32'd1);
    repeat (2) clk_step("t6_drain");

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      bus.mem_valid = ($urandom_range(0, 3) == 0);
      bus.mem_addr  = AW'($urandom_range(0, 7));
      bus.mem_data  = $urandom;
      bus.alu_valid = $urandom_range(0, 1) == 1;
      bus.alu_addr  = AW'($urandom_range(0, 7));
      bus.alu_data  = $urandom;
      bus.rf_hold   = ($urandom_range(0, 2) == 0);
      bus.fwd_addr  = AW'($urandom_range(0, 7));
      clk_step("rand");
    end
    idle_inputs();
    repeat (DEPTH + 1) clk_step("final_drain");
    chk("final_empty", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Producer-side counterpart of the register-file write port: collects writeback results from the ALU and load paths and drives the register file's write-enable/address/data.
- Buffers pending writes in a small in-order FIFO, arbitrates two producers, and exposes a forwarding lookup so decode can read values not yet committed.
- Sits between the execute/memory stages and the register file in the MIPS core.

Parameters:
- DEPTH, 4, number of pending-write entries; must be a power of two, minimum 2.
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- alu_valid  input  1  ALU result offered.
- alu_ready  output  1  ALU result accepted this cycle.
- alu_addr  input  AW  ALU destination register.
- alu_data  input  DW  ALU result.
- mem_valid  input  1  load result offered.
- mem_ready  output  1  load result accepted this cycle.
- mem_addr  input  AW  load destination register.
- mem_data  input  DW  load data.
- rf_hold  input  1  register file cannot take a write this cycle.
- rf_we  output  1  write enable to register file.
- rf_wa  output  AW  write address.
- rf_wd  output  DW  write data.
- fwd_addr  input  AW  forwarding lookup address.
- fwd_hit  output  1  a pending write targets fwd_addr.
- fwd_data  output  DW  youngest pending data for fwd_addr.
- count  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async assert, sync-safe release): wr_ptr=rd_ptr=0, count=0, every entry valid bit cleared. Outputs during reset: rf_we=0, rf_wa=0, rf_wd=0, fwd_hit=0, fwd_data=0, alu_ready=0, mem_ready=0.
- Reset mid-operation: all pending writes are discarded, never written.
- Accept: at most one push per cycle. Transfer occurs when valid && ready at the rising edge.
- Arbitration is fixed priority, mem over alu:
  - mem_ready = (count<DEPTH).
  - alu_ready = (count<DEPTH) && !mem_valid.
- Full (count==DEPTH): both readies low, even if a pop occurs in the same cycle; readies depend on count only, never on pop.
- Drain:
  - rf_we = (count!=0); rf_wa/rf_wd are driven combinationally from the head entry.
  - When empty, rf_wa=0 and rf_wd=0.
  - Pop occurs at the edge where rf_we && !rf_hold.
  - While rf_hold=1, the head is held stable and rf_we stays 1.
- Latency: an entry accepted at edge N is presented on rf_* in cycle N+1. The earliest commit in the register file is edge N+1.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- Ordering: strict FIFO; writes commit in acceptance order.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty is decided from count.
- Forwarding:
  - Purely combinational over entries currently in the queue, including the head being written this cycle.
  - fwd_hit=1 if any valid entry has addr==fwd_addr. fwd_data is the data of the youngest such entry (closest to wr_ptr); fwd_data=0 when fwd_hit=0.
  - Same-cycle input offers are not visible to forwarding.

Optional Feature:
- Macro: WB_DROP_R0_EN.
- Defined: a transfer with addr==0 completes the handshake (ready as above) but is not enqueued. r0 is never written and never produces fwd_hit. fwd_addr==0 always gives fwd_hit=0, fwd_data=0.
- Undefined: addr 0 is treated like any other register (enqueued, written, forwarded).

Decomposition:
- Package regfile_wb_pkg: AW/DW default constants and the entry typedef (valid bit, addr[AW], data[DW]).
- Sub-module regfile_wb_fifo: storage, pointers, count, head read, and the parallel youngest-match search.
- Top level keeps arbitration, r0 filtering and the rf_* output gating.

Test Plan:
- Reset, then alu writes (addr=3, data=0x11) -> alu_ready=1; next cycle rf_we=1, rf_wa=3, rf_wd=0x11; count returns to 0 after one edge.
- mem (addr=2, data=0xAA) and alu (addr=4, data=0xBB) both valid -> mem accepted first, alu_ready=0 that cycle; commit order is r2 then r4.
- rf_hold=1, push 4 entries -> count=4, both readies 0, rf_* stable on the first entry; release hold -> entries drain in order, one per cycle.
- Push r5=1 then r5=2 while holding; fwd_addr=5 -> fwd_hit=1, fwd_data=2; fwd_addr=6 -> fwd_hit=0, fwd_data=0.
- Full with hold released and a new mem offer -> mem_ready=0 in that cycle, count becomes 3; the offer is accepted the next cycle.
- Assert rst_n=0 asynchronously with 3 pending entries -> rf_we drops immediately, count=0, no further writes. With WB_DROP_R0_EN defined: alu addr=0 -> alu_ready=1, count stays 0, rf_we stays 0.
